// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider controller.
package clk_div_pkg;

    localparam int DIV_W_DEF = 28;
    localparam int CFG_CHAN_W = 4;
    localparam int CFG_DIV_W = 32;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_RUN  = 2'd1,
        CH_PEND = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic [CFG_CHAN_W-1:0] chan;
        logic [CFG_DIV_W-1:0]  div;
        logic                  en;
    } cfg_req_t;

    // A zero divisor always means stop, whatever the enable bit says.
    function automatic logic cfg_is_enable(input logic en, input logic [CFG_DIV_W-1:0] div);
        return en && (div != {CFG_DIV_W{1'b0}});
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, run/pending state and tick/square-wave decode.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             div_o,
    output logic             pend_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    ch_state_t        state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] nxt_div_r;
    logic             nxt_en_r;
    logic             run_s;

    // Outputs decode straight from registered state so tick lands on the last count.
    always_comb begin
        run_s  = (state_r != CH_OFF);
        tick_o = run_s && (cnt_r == (div_r - ONE));
        div_o  = run_s && ((div_r == ONE) || (cnt_r < (div_r >> 1)));
        pend_o = (state_r == CH_PEND);
    end

    // Channel state, counter and deferred-update register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= CH_OFF;
            cnt_r     <= {DIV_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            nxt_div_r <= {DIV_W{1'b0}};
            nxt_en_r  <= 1'b0;
        end else if (sync_i && run_s) begin
            cnt_r <= {DIV_W{1'b0}};
            if (state_r == CH_PEND) begin
                state_r <= nxt_en_r ? CH_RUN : CH_OFF;
                div_r   <= nxt_en_r ? nxt_div_r : {DIV_W{1'b0}};
            end else begin
                state_r <= state_r;
            end
        end else begin
            case (state_r)
                CH_OFF: begin
                    if (wr_i && wr_en_i) begin
                        state_r <= CH_RUN;
                        div_r   <= wr_div_i;
                        cnt_r   <= {DIV_W{1'b0}};
                    end else begin
                        cnt_r <= {DIV_W{1'b0}};
                    end
                end
                CH_RUN: begin
                    cnt_r <= tick_o ? {DIV_W{1'b0}} : (cnt_r + ONE);
                    if (wr_i) begin
                        state_r   <= CH_PEND;
                        nxt_div_r <= wr_div_i;
                        nxt_en_r  <= wr_en_i;
                    end else begin
                        state_r <= CH_RUN;
                    end
                end
                CH_PEND: begin
                    // The stored update only lands on the edge that closes a full period.
                    if (tick_o) begin
                        cnt_r   <= {DIV_W{1'b0}};
                        state_r <= nxt_en_r ? CH_RUN : CH_OFF;
                        div_r   <= nxt_en_r ? nxt_div_r : {DIV_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + ONE;
                    end
                end
                default: begin
                    state_r <= CH_OFF;
                    cnt_r   <= {DIV_W{1'b0}};
                    div_r   <= {DIV_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Multi-channel programmable divider: config decode, ready mux and sync fan-out.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W = DIV_W_DEF,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CH_W-1:0]     cfg_chan_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    input  logic                cfg_en_i,
    input  logic                sync_i,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] div_o,
    output logic [CHANNELS-1:0] pend_o
);

    cfg_req_t            req_s;
    logic                pend_sel_s;
    logic                accept_s;
    logic                wr_en_s;
    logic [CHANNELS-1:0] wr_s;

    // Ready depends only on the addressed channel; out-of-range channels never block.
    always_comb begin
        req_s.chan = CFG_CHAN_W'(cfg_chan_i);
        req_s.div  = CFG_DIV_W'(cfg_div_i);
        req_s.en   = cfg_en_i;
        pend_sel_s = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            pend_sel_s = pend_sel_s | ((cfg_chan_i == CH_W'(c)) & pend_o[c]);
        end
        cfg_ready_o = !rst_i && !sync_i && !pend_sel_s;
        accept_s    = cfg_valid_i && cfg_ready_o;
        wr_en_s     = cfg_is_enable(req_s.en, req_s.div);
        for (int c = 0; c < CHANNELS; c++) begin
            wr_s[c] = accept_s && (req_s.chan == CFG_CHAN_W'(c));
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .sync_i   (sync_i),
            .wr_i     (wr_s[c]),
            .wr_en_i  (wr_en_s),
            .wr_div_i (DIV_W'(req_s.div)),
            .tick_o   (tick_o[c]),
            .div_o    (div_o[c]),
            .pend_o   (pend_o[c])
        );
    end

endmodule
